// File: rtl/iurt_pkg.sv
// Shared IURT register map, status-bit positions and host FSM encoding.
package iurt_pkg;

    // Word select on adr[2]
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CTRL = 1'b1;

    // Status-word bit positions, common to host and slave
    localparam int unsigned TXRDY_BIT = 9;
    localparam int unsigned RXVAL_BIT = 8;

    // Host FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_POLL    = 3'd1;
    localparam state_t ST_RD_DATA = 3'd2;
    localparam state_t ST_WR_DATA = 3'd3;
    localparam state_t ST_WR_CTRL = 3'd4;

    // Round-robin turn between rx and tx service
    localparam logic TURN_RX = 1'b0;
    localparam logic TURN_TX = 1'b1;

    // Status word as presented by the slave
    function automatic logic [31:0] status_word(input logic txr, input logic rxv,
                                                input logic [7:0] rx_byte);
        status_word = {22'b0, txr, rxv, rx_byte};
    endfunction

endpackage

// File: rtl/iurt_wb_host.sv
// Wishbone classic initiator servicing an IURT slave: polls status, drains rx bytes into a
// local valid/ready stream, pushes tx bytes from a local stream and arms break on request.
module iurt_wb_host
    import iurt_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter logic [7:0]  TIMEOUT       = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [2:2]  adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    input  logic        brk_arm,
    output logic        timeout_o
);

    localparam int unsigned CntW      = (POLL_INTERVAL < 2) ? 1 : $clog2(POLL_INTERVAL + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(POLL_INTERVAL);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      wait_q, wait_d;
    logic            turn_q, turn_d;
    logic            brk_q, brk_d;
    logic            tx_ready_q, tx_ready_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            timeout_q, timeout_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [2:2]      adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;

    logic acked, expired, tx_serviceable, rx_wanted;

    // Only the status bits and rx byte of the read word are meaningful
    logic unused_dat_hi;
    assign unused_dat_hi = ^dat_i[31:10];

    // Next-state: local streams, break flag, bus launch/retire and FSM sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        turn_d     = turn_q;
        brk_d      = brk_q;
        tx_ready_d = tx_ready_q;
        tx_byte_d  = tx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        timeout_d  = timeout_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;

        acked          = stb_q & ack_i;
        expired        = stb_q & ~ack_i & (wait_q == TIMEOUT - 8'd1);
        tx_serviceable = dat_i[TXRDY_BIT] & ~tx_ready_q;
        rx_wanted      = dat_i[RXVAL_BIT] & ~rx_valid_q;

        if (stb_q && !ack_i) wait_d = wait_q + 8'd1;

        if (tx_valid && tx_ready_q) begin
            tx_ready_d = 1'b0;
            tx_byte_d  = tx_data;
        end
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // A fresh arm during the clearing ack must win
        if (state_q == ST_WR_CTRL && acked) brk_d = 1'b0;
        if (brk_arm) brk_d = 1'b1;

        if (acked || expired) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
        end

        // Access states launch on the first cycle with stb low, which also gives the idle
        // cycle between back-to-back accesses.
        unique case (state_q)
            ST_IDLE: begin
                if (brk_q) begin
                    state_d = ST_WR_CTRL;
                end else if (!tx_ready_q || cnt_q == '0) begin
                    state_d = ST_POLL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_POLL: begin
                if (!stb_q) begin
                    {cyc_d, stb_d, we_d} = 3'b110;
                    adr_d  = ADR_CTRL;
                    dat_d  = '0;
                    wait_d = '0;
                end else if (acked) begin
                    if (brk_q) begin
                        state_d = ST_WR_CTRL;
                    end else if (rx_wanted && (turn_q == TURN_RX || !tx_serviceable)) begin
                        state_d = ST_RD_DATA;
                    end else if (tx_serviceable) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = CntReload;
                    end
                end
            end
            ST_RD_DATA: begin
                if (!stb_q) begin
                    {cyc_d, stb_d, we_d} = 3'b110;
                    adr_d  = ADR_DATA;
                    dat_d  = '0;
                    wait_d = '0;
                end else if (acked) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = dat_i[7:0];
                    turn_d     = ~turn_q;
                    state_d    = ST_POLL;
                end
            end
            ST_WR_DATA: begin
                if (!stb_q) begin
                    {cyc_d, stb_d, we_d} = 3'b111;
                    adr_d  = ADR_DATA;
                    dat_d  = {24'b0, tx_byte_q};
                    wait_d = '0;
                end else if (acked) begin
                    tx_ready_d = 1'b1;
                    turn_d     = ~turn_q;
                    state_d    = ST_POLL;
                end
            end
            ST_WR_CTRL: begin
                if (!stb_q) begin
                    {cyc_d, stb_d, we_d} = 3'b111;
                    adr_d  = ADR_CTRL;
                    dat_d  = 32'd1;
                    wait_d = '0;
                end else if (acked) begin
                    state_d = ST_POLL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abandoned access: tx byte and break flag stay pending for a later retry
        if (expired) begin
            state_d   = ST_IDLE;
            cnt_d     = CntReload;
            timeout_d = 1'b1;
        end
    end

    // State registers; everything holds while ce is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CntReload;
            wait_q     <= '0;
            turn_q     <= TURN_RX;
            brk_q      <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            timeout_q  <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else if (ce) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            turn_q     <= turn_d;
            brk_q      <= brk_d;
            tx_ready_q <= tx_ready_d;
            tx_byte_q  <= tx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            timeout_q  <= timeout_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_iurt_wb_host.sv
// Directed bench for iurt_wb_host with a behavioural IURT slave that acks in the strobe cycle.
module tb_iurt_wb_host;
    import iurt_pkg::*;

    localparam int LOGN = 1024;

    logic        clk = 1'b0;
    logic        rst_n, ce;
    logic        cyc_o, stb_o, we_o;
    logic [2:2]  adr_o;
    logic [31:0] dat_o, dat_i;
    logic        ack_i;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, brk_arm, timeout_o;
    logic [7:0]  tx_data, rx_data;

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration (written only by the stimulus block)
    logic       cfg_txr = 1'b1;
    logic       cfg_block_wr = 1'b0;
    logic [7:0] rx_bytes [16];
    int         rx_avail = 0;

    // Slave state and access log (written only by the slave process)
    int         rx_taken = 0;
    int         cyc_cnt = 0;
    int         stall_cnt = 0;
    int         log_n = 0;
    logic       log_we  [LOGN];
    logic       log_adr [LOGN];
    logic [31:0] log_dat [LOGN];
    int         log_cyc [LOGN];

    // Reader side of the log
    int          rd_idx = 0;
    logic        e_we, e_adr;
    logic [31:0] e_dat;
    logic [9:0]  e_code;
    int          e_cyc;

    logic s_rxv;

    always #5 clk = ~clk;

    iurt_wb_host #(.POLL_INTERVAL(16), .TIMEOUT(8'd255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .brk_arm   (brk_arm),
        .timeout_o (timeout_o)
    );

    assign s_rxv = (rx_taken < rx_avail);
    assign dat_i = (adr_o == ADR_DATA)
                 ? status_word(cfg_txr, s_rxv, s_rxv ? rx_bytes[rx_taken[3:0]] : 8'h00)
                 : status_word(cfg_txr, s_rxv, 8'h00);
    assign ack_i = cyc_o & stb_o & ~(cfg_block_wr & we_o & (adr_o == ADR_DATA));

    // Slave: log completed accesses, pop rx bytes on DATA reads, count stalled strobes
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (cyc_o && stb_o && !ack_i) stall_cnt <= stall_cnt + 1;
        if (cyc_o && stb_o && ack_i) begin
            log_we[log_n % LOGN]  <= we_o;
            log_adr[log_n % LOGN] <= adr_o;
            log_dat[log_n % LOGN] <= we_o ? dat_o : dat_i;
            log_cyc[log_n % LOGN] <= cyc_cnt;
            log_n <= log_n + 1;
            if (!we_o && adr_o == ADR_DATA && s_rxv) rx_taken <= rx_taken + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Fetch the next logged access, optionally skipping CTRL polls; bounded by budget cycles
    task automatic next_access(input string tag, input bit skip_polls, input int budget);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            if (rd_idx < log_n) begin
                e_we   = log_we[rd_idx % LOGN];
                e_adr  = log_adr[rd_idx % LOGN];
                e_dat  = log_dat[rd_idx % LOGN];
                e_cyc  = log_cyc[rd_idx % LOGN];
                e_code = {e_we, e_adr, e_dat[7:0]};
                rd_idx++;
                if (!(skip_polls && !e_we && e_adr == ADR_CTRL)) got = 1'b1;
            end else begin
                tick(1);
                n++;
            end
        end
        if (!got) begin
            e_code = 'x;
            e_dat  = 'x;
        end
        check({tag, "_seen"}, {31'b0, got}, 32'd1);
    endtask

    initial begin
        int c1;
        int c_prev;
        int s0;
        logic [9:0] exp_seq [6];

        rst_n    = 1'b0;
        ce       = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        brk_arm  = 1'b0;
        for (int i = 0; i < 16; i++) rx_bytes[i] = 8'h00;
        rx_bytes[0] = 8'h5A;
        rx_avail    = 1;

        // Reset state
        tick(3);
        check("rst_bus_ctl", {28'b0, cyc_o, stb_o, we_o, adr_o}, 32'h0);
        check("rst_dat_o", dat_o, 32'h0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data}, 32'h0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_timeout", {31'b0, timeout_o}, 32'd0);
        rst_n = 1'b1;

        // Rx byte 0x5A: CTRL poll then DATA read
        next_access("rx_poll", 1'b0, 100);
        check("rx_poll_word", e_dat, 32'h300);
        check("rx_poll_kind", {22'b0, e_code[9:8], 8'h0}, 32'h100);
        c1 = e_cyc;
        next_access("rx_read", 1'b0, 100);
        check("rx_read_code", {22'b0, e_code}, 32'h05A);
        check("rx_latency", e_cyc - c1, 32'd2);
        check("rx_valid_set", {31'b0, rx_valid}, 32'd1);
        check("rx_data_5a", {24'b0, rx_data}, 32'h5A);
        check("rx_slave_pop", rx_taken, 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("rx_consumed", {31'b0, rx_valid}, 32'd0);

        // Tx byte 0xA3
        rd_idx   = log_n;
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("tx_held", {31'b0, tx_ready}, 32'd0);
        next_access("tx_write", 1'b1, 100);
        check("tx_write_code", {22'b0, e_code}, 32'h2A3);
        check("tx_write_dat", e_dat, 32'h0000_00A3);
        check("tx_freed", {31'b0, tx_ready}, 32'd1);

        // Rx and tx both pending: alternate, then rx-only once tx runs dry
        rd_idx      = log_n;
        rx_bytes[1] = 8'h11;
        rx_bytes[2] = 8'h22;
        rx_bytes[3] = 8'h33;
        rx_bytes[4] = 8'h44;
        rx_ready    = 1'b1;
        tx_data     = 8'h77;
        tx_valid    = 1'b1;
        rx_avail    = 5;
        exp_seq[0] = 10'h011;
        exp_seq[1] = 10'h277;
        exp_seq[2] = 10'h022;
        exp_seq[3] = 10'h277;
        exp_seq[4] = 10'h033;
        exp_seq[5] = 10'h044;
        for (int i = 0; i < 6; i++) begin
            next_access($sformatf("rr_%0d", i), 1'b1, 200);
            if (i == 3) tx_valid = 1'b0;
            check($sformatf("rr_code_%0d", i), {22'b0, e_code}, {22'b0, exp_seq[i]});
        end
        rx_ready = 1'b0;

        // Output full while the slave still has a byte: polls only, evenly spaced
        rx_bytes[5] = 8'h66;
        rx_avail    = 6;
        check("bp_rx_valid", {31'b0, rx_valid}, 32'd1);
        check("bp_rx_data", {24'b0, rx_data}, 32'h44);
        c_prev = 0;
        for (int i = 0; i < 3; i++) begin
            next_access($sformatf("bp_%0d", i), 1'b0, 100);
            check($sformatf("bp_kind_%0d", i), {30'b0, e_we, e_adr}, 32'd1);
            if (i > 0) check($sformatf("bp_gap_%0d", i), e_cyc - c_prev, 32'd19);
            c_prev = e_cyc;
        end
        check("bp_slave_kept", rx_taken, 32'd5);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("bp_released", {31'b0, rx_valid}, 32'd0);
        next_access("bp_drain", 1'b1, 100);
        check("bp_drain_code", {22'b0, e_code}, 32'h066);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;

        // Slave withholds ack on the DATA write
        rd_idx       = log_n;
        s0           = stall_cnt;
        cfg_block_wr = 1'b1;
        tx_data      = 8'hA5;
        tx_valid     = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int i = 0; i < 600 && !timeout_o; i++) tick(1);
        check("to_flag", {31'b0, timeout_o}, 32'd1);
        check("to_stalls", stall_cnt - s0, 32'd255);
        check("to_bus_idle", {31'b0, cyc_o}, 32'd0);
        check("to_tx_kept", {31'b0, tx_ready}, 32'd0);
        cfg_block_wr = 1'b0;
        next_access("to_retry", 1'b1, 100);
        check("to_retry_code", {22'b0, e_code}, 32'h2A5);
        check("to_retry_freed", {31'b0, tx_ready}, 32'd1);
        check("to_sticky", {31'b0, timeout_o}, 32'd1);

        // Break armed while an rx read is on the bus
        rd_idx      = log_n;
        rx_bytes[6] = 8'hC3;
        rx_avail    = 7;
        for (int i = 0; i < 100 && !(stb_o && !we_o && adr_o == ADR_DATA); i++) tick(1);
        brk_arm = 1'b1;
        tick(1);
        brk_arm = 1'b0;
        next_access("brk_rd", 1'b1, 100);
        check("brk_rd_code", {22'b0, e_code}, 32'h0C3);
        next_access("brk_wr", 1'b1, 100);
        check("brk_wr_code", {22'b0, e_code}, 32'h301);
        check("brk_wr_dat", e_dat, 32'd1);

        // Asynchronous reset mid-access
        for (int i = 0; i < 100 && !stb_o; i++) tick(1);
        check("ar_in_access", {31'b0, stb_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_cyc_drop", {30'b0, cyc_o, stb_o}, 32'd0);
        check("ar_timeout_clr", {31'b0, timeout_o}, 32'd0);
        check("ar_rx_clr", {31'b0, rx_valid}, 32'd0);
        check("ar_tx_ready", {31'b0, tx_ready}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
